// File: rtl/control_fsm_if.sv
// Control bundle between the multicycle controller and the datapath it steers.
// master = controller side, slave = datapath side.
interface control_fsm_if;
  logic [5:0]  opCode;
  logic        PCWriteCond;
  logic        PCWrite;
  logic        IorD;
  logic        MemRead;
  logic        MemWrite;
  logic        MemtoReg;
  logic        IRWrite;
  logic        ALUSrcA;
  logic        RegWrite;
  logic        RegDst;
  logic [1:0]  PCSource;
  logic [1:0]  ALUSrcB;
  logic [1:0]  ALUOp;
  logic [3:0]  state;
  logic        halted;
  logic        illegal;
  logic [15:0] retired;

  modport master (
    input  opCode,
    output PCWriteCond, PCWrite, IorD, MemRead, MemWrite, MemtoReg, IRWrite,
           ALUSrcA, RegWrite, RegDst, PCSource, ALUSrcB, ALUOp,
           state, halted, illegal, retired
  );

  modport slave (
    output opCode,
    input  PCWriteCond, PCWrite, IorD, MemRead, MemWrite, MemtoReg, IRWrite,
           ALUSrcA, RegWrite, RegDst, PCSource, ALUSrcB, ALUOp,
           state, halted, illegal, retired
  );
endinterface

// File: rtl/control_fsm.sv
// Multicycle MIPS-style controller: Moore-decoded datapath strobes, retire counter, halt/illegal status.
// Latency 4-6 cycles per instruction (beq/j 4, sw/R/addi 5, lw 6); no backpressure, advances every cycle.
module control_fsm (
  input  logic          clk,
  input  logic          reset,
  control_fsm_if.master bus
);

  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    FETCH2  = 4'd1,
    DECODE  = 4'd2,
    MEMADR  = 4'd3,
    MEMRD   = 4'd4,
    MEMWB   = 4'd5,
    MEMWR   = 4'd6,
    RTEXE   = 4'd7,
    RTWB    = 4'd8,
    BRANCH  = 4'd9,
    JUMP    = 4'd10,
    ADDIEXE = 4'd11,
    ADDIWB  = 4'd12,
    HALT    = 4'd13
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_HALT  = 6'b111111;

  state_t      state_q;
  state_t      state_d;
  logic        store_q;
  logic        illegal_q;
  logic [15:0] retired_q;
  logic        op_known;
  logic        retire;

  always_comb begin
    op_known = 1'b0;
    case (bus.opCode)
      OP_RTYPE, OP_J, OP_BEQ, OP_ADDI,
      OP_LW, OP_SW, OP_HALT: op_known = 1'b1;
      default:               op_known = 1'b0;
    endcase
  end

  // Next state plus the retire strobe that marks the edge an instruction completes on.
  always_comb begin
    state_d = FETCH;
    retire  = 1'b0;
    case (state_q)
      FETCH:   state_d = FETCH2;
      FETCH2:  state_d = DECODE;
      DECODE: begin
        case (bus.opCode)
          OP_LW, OP_SW: state_d = MEMADR;
          OP_RTYPE:     state_d = RTEXE;
          OP_BEQ:       state_d = BRANCH;
          OP_J:         state_d = JUMP;
          OP_ADDI:      state_d = ADDIEXE;
          OP_HALT: begin
            state_d = HALT;
            retire  = 1'b1;
          end
          default:      state_d = FETCH;
        endcase
      end
      MEMADR:  state_d = store_q ? MEMWR : MEMRD;
      MEMRD:   state_d = MEMWB;
      RTEXE:   state_d = RTWB;
      ADDIEXE: state_d = ADDIWB;
      MEMWB, MEMWR, RTWB, BRANCH, JUMP, ADDIWB: begin
        state_d = FETCH;
        retire  = 1'b1;
      end
      HALT:    state_d = HALT;
      default: state_d = FETCH;
    endcase
  end

  // Moore output decode; anything not named for a state stays 0.
  always_comb begin
    bus.PCWriteCond = 1'b0;
    bus.PCWrite     = 1'b0;
    bus.IorD        = 1'b0;
    bus.MemRead     = 1'b0;
    bus.MemWrite    = 1'b0;
    bus.MemtoReg    = 1'b0;
    bus.IRWrite     = 1'b0;
    bus.ALUSrcA     = 1'b0;
    bus.RegWrite    = 1'b0;
    bus.RegDst      = 1'b0;
    bus.PCSource    = 2'b00;
    bus.ALUSrcB     = 2'b00;
    bus.ALUOp       = 2'b00;
    case (state_q)
      FETCH: begin
        bus.MemRead = 1'b1;
      end
      FETCH2: begin
        bus.IRWrite = 1'b1;
        bus.ALUSrcB = 2'b01;
        bus.PCWrite = 1'b1;
      end
      MEMADR, ADDIEXE: begin
        bus.ALUSrcA = 1'b1;
        bus.ALUSrcB = 2'b10;
      end
      MEMRD: begin
        bus.ALUSrcA = 1'b1;
        bus.ALUSrcB = 2'b10;
        bus.IorD    = 1'b1;
        bus.MemRead = 1'b1;
      end
      MEMWB: begin
        bus.ALUSrcA  = 1'b1;
        bus.ALUSrcB  = 2'b10;
        bus.IorD     = 1'b1;
        bus.MemtoReg = 1'b1;
        bus.RegWrite = 1'b1;
      end
      MEMWR: begin
        bus.ALUSrcA  = 1'b1;
        bus.ALUSrcB  = 2'b10;
        bus.IorD     = 1'b1;
        bus.MemWrite = 1'b1;
      end
      RTEXE: begin
        bus.ALUSrcA = 1'b1;
        bus.ALUOp   = 2'b10;
      end
      RTWB: begin
        bus.ALUSrcA  = 1'b1;
        bus.ALUOp    = 2'b10;
        bus.RegDst   = 1'b1;
        bus.RegWrite = 1'b1;
      end
      BRANCH: begin
        bus.ALUSrcA     = 1'b1;
        bus.ALUOp       = 2'b01;
        bus.PCWriteCond = 1'b1;
        bus.PCSource    = 2'b01;
      end
      JUMP: begin
        bus.PCSource = 2'b10;
        bus.PCWrite  = 1'b1;
      end
      ADDIWB: begin
        bus.ALUSrcA  = 1'b1;
        bus.ALUSrcB  = 2'b10;
        bus.RegWrite = 1'b1;
      end
      default: begin
      end
    endcase
  end

  // The opcode is only guaranteed valid in DECODE, so lw/sw is remembered for MEMADR.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= FETCH;
      store_q   <= 1'b0;
      illegal_q <= 1'b0;
      retired_q <= 16'h0000;
    end else begin
      state_q   <= state_d;
      illegal_q <= (state_q == DECODE) && !op_known;
      if (state_q == DECODE)
        store_q <= (bus.opCode == OP_SW);
      if (retire)
        retired_q <= retired_q + 16'd1;
    end
  end

  assign bus.state   = state_q;
  assign bus.halted  = (state_q == HALT);
  assign bus.illegal = illegal_q;
  assign bus.retired = retired_q;

endmodule

// File: tb/tb_control_fsm.sv
// Directed-vector bench for control_fsm: per-state strobes, sequencing, retire count, halt, illegal, reset abort.
module tb_control_fsm;

  logic        clk   = 1'b0;
  logic        reset = 1'b0;
  int          errors = 0;
  int          checks = 0;
  logic [15:0] exp_ret;
  logic [15:0] ctl;

  control_fsm_if bus();

  control_fsm dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  assign ctl = {bus.PCWriteCond, bus.PCWrite, bus.IorD, bus.MemRead, bus.MemWrite,
                bus.MemtoReg, bus.IRWrite, bus.ALUSrcA, bus.RegWrite, bus.RegDst,
                bus.PCSource, bus.ALUSrcB, bus.ALUOp};

  // Hand-packed control word per state, bit order as in ctl above.
  function automatic logic [15:0] exp_ctl(input logic [3:0] s);
    case (s)
      4'd0:    return 16'h1000;
      4'd1:    return 16'h4204;
      4'd3:    return 16'h0108;
      4'd4:    return 16'h3108;
      4'd5:    return 16'h2588;
      4'd6:    return 16'h2908;
      4'd7:    return 16'h0102;
      4'd8:    return 16'h01C2;
      4'd9:    return 16'h8111;
      4'd10:   return 16'h4020;
      4'd11:   return 16'h0108;
      4'd12:   return 16'h0188;
      default: return 16'h0000;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    bus.opCode = 6'b000000;
    #1 reset = 1'b1;
    #2;
    checks++; if (bus.state !== 4'd0) begin errors++; $display("FAIL reset_state: got %0d want 0", bus.state); end
    checks++; if (ctl !== 16'h1000) begin errors++; $display("FAIL reset_ctl: got %h want 1000", ctl); end
    checks++; if (bus.retired !== 16'h0000) begin errors++; $display("FAIL reset_retired: got %h want 0000", bus.retired); end
    checks++; if (bus.illegal !== 1'b0 || bus.halted !== 1'b0) begin errors++; $display("FAIL reset_flags: got illegal=%b halted=%b want 0 0", bus.illegal, bus.halted); end
    tick();
    checks++; if (bus.state !== 4'd0) begin errors++; $display("FAIL reset_hold: got %0d want 0", bus.state); end
    reset   = 1'b0;
    exp_ret = 16'h0000;
  endtask

  task automatic test_rtype();
    logic [3:0] seq [6];
    seq = '{4'd0, 4'd1, 4'd2, 4'd7, 4'd8, 4'd0};
    bus.opCode = 6'b000000;
    for (int i = 0; i < 6; i++) begin
      if (i > 0) tick();
      if (i > 0 && seq[i] == 4'd0) exp_ret++;
      checks++; if (bus.state !== seq[i]) begin errors++; $display("FAIL rtype_state[%0d]: got %0d want %0d", i, bus.state, seq[i]); end
      checks++; if (ctl !== exp_ctl(seq[i])) begin errors++; $display("FAIL rtype_ctl[%0d]: got %h want %h", i, ctl, exp_ctl(seq[i])); end
      checks++; if (bus.retired !== exp_ret) begin errors++; $display("FAIL rtype_retired[%0d]: got %h want %h", i, bus.retired, exp_ret); end
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] seq [12];
    seq = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd0, 4'd1, 4'd2, 4'd3, 4'd6, 4'd0};
    bus.opCode = 6'b100011;
    for (int i = 0; i < 12; i++) begin
      if (i > 0) tick();
      if (i == 6) bus.opCode = 6'b101011;
      if (i > 0 && seq[i] == 4'd0) exp_ret++;
      checks++; if (bus.state !== seq[i]) begin errors++; $display("FAIL lwsw_state[%0d]: got %0d want %0d", i, bus.state, seq[i]); end
      checks++; if (ctl !== exp_ctl(seq[i])) begin errors++; $display("FAIL lwsw_ctl[%0d]: got %h want %h", i, ctl, exp_ctl(seq[i])); end
      checks++; if (bus.retired !== exp_ret) begin errors++; $display("FAIL lwsw_retired[%0d]: got %h want %h", i, bus.retired, exp_ret); end
    end
  endtask

  task automatic test_branch_jump();
    logic [3:0] seq [9];
    seq = '{4'd0, 4'd1, 4'd2, 4'd9, 4'd0, 4'd1, 4'd2, 4'd10, 4'd0};
    bus.opCode = 6'b000100;
    for (int i = 0; i < 9; i++) begin
      if (i > 0) tick();
      if (i == 4) bus.opCode = 6'b000010;
      if (i > 0 && seq[i] == 4'd0) exp_ret++;
      checks++; if (bus.state !== seq[i]) begin errors++; $display("FAIL brj_state[%0d]: got %0d want %0d", i, bus.state, seq[i]); end
      checks++; if (ctl !== exp_ctl(seq[i])) begin errors++; $display("FAIL brj_ctl[%0d]: got %h want %h", i, ctl, exp_ctl(seq[i])); end
      checks++; if (bus.retired !== exp_ret) begin errors++; $display("FAIL brj_retired[%0d]: got %h want %h", i, bus.retired, exp_ret); end
    end
  endtask

  task automatic test_addi();
    logic [3:0] seq [6];
    seq = '{4'd0, 4'd1, 4'd2, 4'd11, 4'd12, 4'd0};
    bus.opCode = 6'b001000;
    for (int i = 0; i < 6; i++) begin
      if (i > 0) tick();
      if (i > 0 && seq[i] == 4'd0) exp_ret++;
      checks++; if (bus.state !== seq[i]) begin errors++; $display("FAIL addi_state[%0d]: got %0d want %0d", i, bus.state, seq[i]); end
      checks++; if (ctl !== exp_ctl(seq[i])) begin errors++; $display("FAIL addi_ctl[%0d]: got %h want %h", i, ctl, exp_ctl(seq[i])); end
      checks++; if (bus.retired !== exp_ret) begin errors++; $display("FAIL addi_retired[%0d]: got %h want %h", i, bus.retired, exp_ret); end
    end
  endtask

  // Unknown opcode falls back to FETCH with a one-cycle illegal pulse, then a j completes normally.
  task automatic test_illegal();
    logic [3:0] seq [8];
    seq = '{4'd0, 4'd1, 4'd2, 4'd0, 4'd1, 4'd2, 4'd10, 4'd0};
    bus.opCode = 6'b010101;
    for (int i = 0; i < 8; i++) begin
      if (i > 0) tick();
      if (i == 3) bus.opCode = 6'b000010;
      if (i == 7) exp_ret++;
      checks++; if (bus.state !== seq[i]) begin errors++; $display("FAIL illegal_state[%0d]: got %0d want %0d", i, bus.state, seq[i]); end
      checks++; if (bus.illegal !== (i == 3)) begin errors++; $display("FAIL illegal_pulse[%0d]: got %b want %b", i, bus.illegal, (i == 3)); end
      checks++; if (bus.retired !== exp_ret) begin errors++; $display("FAIL illegal_retired[%0d]: got %h want %h", i, bus.retired, exp_ret); end
    end
  endtask

  task automatic test_wrap();
    logic [3:0] seq [5];
    seq = '{4'd0, 4'd1, 4'd2, 4'd10, 4'd0};
    force dut.retired_q = 16'hFFFF;
    #1;
    release dut.retired_q;
    exp_ret = 16'hFFFF;
    bus.opCode = 6'b000010;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) tick();
      if (i == 4) exp_ret++;
      checks++; if (bus.state !== seq[i]) begin errors++; $display("FAIL wrap_state[%0d]: got %0d want %0d", i, bus.state, seq[i]); end
      checks++; if (bus.retired !== exp_ret) begin errors++; $display("FAIL wrap_retired[%0d]: got %h want %h", i, bus.retired, exp_ret); end
    end
  endtask

  // Reset landing between edges while a store is in MEMWR.
  task automatic test_abort_store();
    bus.opCode = 6'b101011;
    for (int i = 0; i < 4; i++) tick();
    checks++; if (bus.state !== 4'd6 || bus.MemWrite !== 1'b1) begin errors++; $display("FAIL abort_memwr: got state=%0d MemWrite=%b want 6 1", bus.state, bus.MemWrite); end
    #2 reset = 1'b1;
    #1;
    exp_ret = 16'h0000;
    checks++; if (bus.state !== 4'd0) begin errors++; $display("FAIL abort_state: got %0d want 0", bus.state); end
    checks++; if (ctl !== 16'h1000) begin errors++; $display("FAIL abort_ctl: got %h want 1000", ctl); end
    checks++; if (bus.retired !== exp_ret) begin errors++; $display("FAIL abort_retired: got %h want %h", bus.retired, exp_ret); end
    tick();
    reset = 1'b0;
    bus.opCode = 6'b000010;
    tick();
    checks++; if (bus.state !== 4'd1) begin errors++; $display("FAIL abort_resume: got %0d want 1", bus.state); end
    tick(); tick(); tick();
    exp_ret++;
    checks++; if (bus.state !== 4'd0 || bus.retired !== exp_ret) begin errors++; $display("FAIL abort_after_j: got state=%0d retired=%h want 0 %h", bus.state, bus.retired, exp_ret); end
  endtask

  task automatic test_halt();
    bus.opCode = 6'b111111;
    tick(); tick(); tick();
    exp_ret++;
    checks++; if (bus.state !== 4'd13) begin errors++; $display("FAIL halt_enter: got %0d want 13", bus.state); end
    checks++; if (bus.retired !== exp_ret) begin errors++; $display("FAIL halt_retired: got %h want %h", bus.retired, exp_ret); end
    bus.opCode = 6'b000000;
    for (int i = 0; i < 20; i++) begin
      tick();
      checks++; if (bus.state !== 4'd13 || bus.halted !== 1'b1) begin errors++; $display("FAIL halt_hold[%0d]: got state=%0d halted=%b want 13 1", i, bus.state, bus.halted); end
      checks++; if (ctl !== 16'h0000) begin errors++; $display("FAIL halt_ctl[%0d]: got %h want 0000", i, ctl); end
      checks++; if (bus.retired !== exp_ret) begin errors++; $display("FAIL halt_count[%0d]: got %h want %h", i, bus.retired, exp_ret); end
    end
    #3 reset = 1'b1;
    #1;
    checks++; if (bus.state !== 4'd0 || bus.halted !== 1'b0) begin errors++; $display("FAIL halt_reset: got state=%0d halted=%b want 0 0", bus.state, bus.halted); end
    checks++; if (bus.retired !== 16'h0000 || ctl !== 16'h1000) begin errors++; $display("FAIL halt_reset_out: got retired=%h ctl=%h want 0000 1000", bus.retired, ctl); end
    tick();
    reset = 1'b0;
    tick();
    checks++; if (bus.state !== 4'd1) begin errors++; $display("FAIL halt_resume: got %0d want 1", bus.state); end
  endtask

  initial begin
    test_reset();
    test_rtype();
    test_back_to_back();
    test_branch_jump();
    test_addi();
    test_illegal();
    test_wrap();
    test_abort_store();
    test_halt();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/control_fsm.md
CONTROL_FSM -- requirements
Module: control_fsm

Interface
REQ-001 clk  input  1  system clock; all state changes on rising edge.
REQ-002 reset  input  1  asynchronous, active-high; forces the reset state immediately, regardless of clk.
REQ-003 opCode  input  6  instruction opcode from the instruction register.
REQ-004 PCWriteCond, PCWrite, IorD, MemRead, MemWrite, MemtoReg, IRWrite, ALUSrcA, RegWrite, RegDst  output  1 each  datapath control strobes and selects.
REQ-005 PCSource  output  2  PC input select: 00 ALU, 01 ALU (branch), 10 jump target.
REQ-006 ALUSrcB  output  2  ALU B select: 00 B, 01 constant 1, 10 sign-extended immediate, 11 shifted immediate.
REQ-007 ALUOp  output  2  00 add, 01 subtract, 10 use function field.
REQ-008 state  output  4  current state encoding, for debug.
REQ-009 halted  output  1  high while in HALT.
REQ-010 illegal  output  1  one-cycle pulse on an unrecognised opcode.
REQ-011 retired  output  16  count of completed instructions.

Function
REQ-012 Outputs SHALL be Moore-decoded from state only; any control signal not listed for a state SHALL be 0.
REQ-013 State encodings SHALL be: FETCH=0, FETCH2=1, DECODE=2, MEMADR=3, MEMRD=4, MEMWB=5, MEMWR=6, RTEXE=7, RTWB=8, BRANCH=9, JUMP=10, ADDIEXE=11, ADDIWB=12, HALT=13; codes 14-15 SHALL go to FETCH on the next edge.
REQ-014 FETCH: MemRead=1, IorD=0; next state FETCH2. The memory read takes one cycle.
REQ-015 FETCH2: IRWrite=1, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00, PCWrite=1; next state DECODE.
REQ-016 DECODE: no strobes; opCode is sampled here. Transitions:
- 100011 (lw) or 101011 (sw) -> MEMADR
- 000000 (R-type) -> RTEXE
- 000100 (beq) -> BRANCH
- 000010 (j) -> JUMP
- 001000 (addi) -> ADDIEXE
- 111111 (halt) -> HALT
- any other opcode -> FETCH, with illegal=1 on that edge's following cycle
REQ-017 MEMADR: ALUSrcA=1, ALUSrcB=10, ALUOp=00; next state MEMRD for lw, MEMWR for sw.
REQ-018 MEMRD: MEMADR ALU settings held, IorD=1, MemRead=1; next state MEMWB.
REQ-019 MEMWB: MEMADR ALU settings held, IorD=1, MemtoReg=1, RegDst=0, RegWrite=1; next state FETCH.
REQ-020 MEMWR: MEMADR ALU settings held, IorD=1, MemWrite=1; next state FETCH.
REQ-021 RTEXE: ALUSrcA=1, ALUSrcB=00, ALUOp=10; next state RTWB.
REQ-022 RTWB: RTEXE ALU settings held, RegDst=1, MemtoReg=0, RegWrite=1; next state FETCH.
REQ-023 BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01; next state FETCH.
REQ-024 JUMP: PCSource=10, PCWrite=1; next state FETCH.
REQ-025 ADDIEXE: ALUSrcA=1, ALUSrcB=10, ALUOp=00; next state ADDIWB.
REQ-026 ADDIWB: ADDIEXE ALU settings held, RegDst=0, MemtoReg=0, RegWrite=1; next state FETCH.
REQ-027 HALT: all strobes 0, halted=1; HALT SHALL be left only by reset.
REQ-028 retired SHALL increment by 1 on every edge leaving MEMWB, MEMWR, RTWB, BRANCH, JUMP, ADDIWB, and on the edge entering HALT; it SHALL wrap from 0xFFFF to 0x0000.
REQ-029 Instruction latency in cycles: lw 6; sw 5; R-type 5; addi 5; beq 4; j 4.

Reset
REQ-030 Reset assertion SHALL immediately set state=FETCH, retired=0, illegal=0, halted=0, with all strobes at the FETCH values (MemRead=1, all others 0).
REQ-031 Reset asserted mid-instruction (including MEMWR or HALT) SHALL abort the instruction, with no further RegWrite/MemWrite; the FSM SHALL resume at FETCH on the first edge after deassertion.

Verification
REQ-032 Reset, then opCode=000000 held -> state sequence 0,1,2,7,8,0; RegWrite=1 only in state 8 with RegDst=1; retired=1 after the sequence.
REQ-033 opCode=100011 -> states 0,1,2,3,4,5,0; MemtoReg=1 and RegWrite=1 only in state 5; IorD=1 in states 4-5.
REQ-034 opCode=000100 -> PCWriteCond=1 and ALUOp=01 only in state 9; PCWrite=1 only in state 1.
REQ-035 opCode=010101 at DECODE -> next state 0, illegal high exactly one cycle, retired unchanged.
REQ-036 opCode=111111 -> state 13 persists for 20 cycles with halted=1 and retired incremented once; assert reset asynchronously between edges -> state=0 before the next edge.
REQ-037 Force retired=0xFFFF, then complete one j instruction -> retired=0x0000.
